// File: rtl/mac_result_fifo.sv
// mac_result_fifo
// Show-ahead result FIFO that sits behind the MAC array. It also keeps a
// running signed maximum of every result offered to it and a sticky flag
// recording that a result was lost because the FIFO was full.
// DEPTH must be a power of two in the range 2..16 so that the pointers can
// wrap naturally by overflowing.

module mac_result_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 11
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [DW-1:0]        in_data,
  input  logic                        in_valid,
  output logic signed [DW-1:0]        dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty,
  output logic                        drop_err,
  output logic signed [DW-1:0]        max_val,
  input  logic                        clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]        FULL_COUNT = CW'(DEPTH);
  localparam logic signed [DW-1:0] MOST_NEG   = {1'b1, {(DW-1){1'b0}}};

  logic signed [DW-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 push;
  logic                 pop;
  logic                 drop;

  // Status flags are decoded straight from the count register
  assign full       = (count == FULL_COUNT);
  assign empty      = (count == '0);
  assign dout_valid = !empty;

  // Head of the FIFO is read from storage, so dout never depends on in_data
  assign dout = mem[rd_ptr];

  // A pop frees a slot in the same cycle, which lets a push proceed when full
  assign pop  = dout_valid && dout_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && !push;

  // Storage array is write-only-on-push and deliberately carries no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as clr wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_err <= 1'b0;
    end else if (drop) begin
      drop_err <= 1'b1;
    end else if (clr) begin
      drop_err <= 1'b0;
    end
  end

  // Running signed maximum over every offered result, dropped ones included
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_val <= MOST_NEG;
    end else if (in_valid) begin
      if (clr || (in_data > max_val)) begin
        max_val <= in_data;
      end
    end else if (clr) begin
      max_val <= MOST_NEG;
    end
  end

endmodule

// File: tb/tb_mac_result_fifo.sv
// tb_mac_result_fifo
// Table-driven vectors, hand-written corner sequences and a randomized run,
// all compared against a queue-based reference model of the result FIFO.

module tb_mac_result_fifo;

  localparam int DEPTH = 8;
  localparam int DW    = 11;
  localparam int MINV  = -1024;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic signed [DW-1:0]   in_data = '0;
  logic                   in_valid = 1'b0;
  logic signed [DW-1:0]   dout;
  logic                   dout_valid;
  logic                   dout_ready = 1'b0;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;
  logic                   drop_err;
  logic signed [DW-1:0]   max_val;
  logic                   clr = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int q[$];
  int m_err;
  int m_max;

  typedef struct {
    bit iv;
    int d;
    bit rdy;
    bit clr;
    int e_count;
    bit e_valid;
    int e_dout;
    int e_max;
    bit e_err;
  } vec_t;

  vec_t tbl[10];
  int   exp_drain[8];

  mac_result_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .drop_err   (drop_err),
    .max_val    (max_val),
    .clr        (clr)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    m_err = 0;
    m_max = MINV;
  endtask

  // Drive one cycle of inputs, advance the model by the same rules, then
  // land 1 time unit after the active edge
  task automatic applyStimulus(input bit iv, input int d, input bit rdy, input bit c);
    bit m_pop;
    bit m_push;
    in_valid   = iv;
    in_data    = DW'(d);
    dout_ready = rdy;
    clr        = c;
    m_pop  = (q.size() > 0) && rdy;
    m_push = iv && ((q.size() < DEPTH) || m_pop);
    if (m_pop) void'(q.pop_front());
    if (m_push) q.push_back(d);
    if (iv && !m_push) m_err = 1;
    else if (c) m_err = 0;
    if (iv) begin
      if (c || d > m_max) m_max = d;
    end else if (c) begin
      m_max = MINV;
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    dout_ready = 1'b0;
    clr        = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, " count"}, int'(count), q.size());
    checkValue({tag, " empty"}, int'(empty), int'(q.size() == 0));
    checkValue({tag, " full"}, int'(full), int'(q.size() == DEPTH));
    checkValue({tag, " dout_valid"}, int'(dout_valid), int'(q.size() != 0));
    if (q.size() != 0) checkValue({tag, " dout"}, int'(dout), q[0]);
    checkValue({tag, " drop_err"}, int'(drop_err), m_err);
    checkValue({tag, " max_val"}, int'(max_val), m_max);
  endtask

  initial begin
    tbl[0] = '{1, 37,   0, 0, 1, 1, 37,   37,   0};
    tbl[1] = '{1, -5,   0, 0, 2, 1, 37,   37,   0};
    tbl[2] = '{0, 0,    1, 0, 1, 1, -5,   37,   0};
    tbl[3] = '{1, 200,  1, 0, 1, 1, 200,  200,  0};
    tbl[4] = '{0, 0,    0, 1, 1, 1, 200,  MINV, 0};
    tbl[5] = '{1, -300, 0, 0, 2, 1, 200,  -300, 0};
    tbl[6] = '{1, -12,  0, 0, 3, 1, 200,  -12,  0};
    tbl[7] = '{1, -700, 0, 1, 4, 1, 200,  -700, 0};
    tbl[8] = '{0, 0,    1, 0, 3, 1, -300, -700, 0};
    tbl[9] = '{1, 1023, 0, 0, 4, 1, -300, 1023, 0};
    exp_drain = '{2, 3, 4, 5, 6, 7, 8, -5};

    // Power-on reset
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset count", int'(count), 0);
    checkValue("reset empty", int'(empty), 1);
    checkValue("reset full", int'(full), 0);
    checkValue("reset dout_valid", int'(dout_valid), 0);
    checkValue("reset drop_err", int'(drop_err), 0);
    checkValue("reset max_val", int'(max_val), MINV);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Vector table
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].iv, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      checkValue($sformatf("vec%0d count", i), int'(count), tbl[i].e_count);
      checkValue($sformatf("vec%0d dout_valid", i), int'(dout_valid), int'(tbl[i].e_valid));
      checkValue($sformatf("vec%0d dout", i), int'(dout), tbl[i].e_dout);
      checkValue($sformatf("vec%0d max_val", i), int'(max_val), tbl[i].e_max);
      checkValue($sformatf("vec%0d drop_err", i), int'(drop_err), int'(tbl[i].e_err));
    end

    // Drain what the table left behind
    for (int i = 0; i < DEPTH + 2 && q.size() > 0; i++) begin
      applyStimulus(0, 0, 1, 0);
      checkOutput("drain1");
    end
    checkValue("drain1 empty", int'(empty), 1);

    // Fill and overflow
    applyStimulus(0, 0, 0, 1);
    for (int v = 1; v <= 9; v++) begin
      applyStimulus(1, v, 0, 0);
      checkOutput($sformatf("fill%0d", v));
    end
    checkValue("ovf full", int'(full), 1);
    checkValue("ovf count", int'(count), 8);
    checkValue("ovf drop_err", int'(drop_err), 1);
    checkValue("ovf max_val", int'(max_val), 9);
    checkValue("ovf dout", int'(dout), 1);

    // Push and pop together while full
    applyStimulus(1, -5, 1, 0);
    checkValue("fullpp count", int'(count), 8);
    checkValue("fullpp drop_err", int'(drop_err), 1);
    checkValue("fullpp dout", int'(dout), 2);
    for (int i = 0; i < 8; i++) begin
      checkValue($sformatf("drain2 dout%0d", i), int'(dout), exp_drain[i]);
      applyStimulus(0, 0, 1, 0);
    end
    checkValue("drain2 empty", int'(empty), 1);
    checkValue("drain2 count", int'(count), 0);

    // Pointer wrap with push/pop pairs
    for (int i = 0; i < 20; i++) begin
      int v;
      v = int'($urandom_range(0, 2047)) - 1024;
      applyStimulus(1, v, 0, 0);
      checkValue($sformatf("wrap%0d dout", i), int'(dout), v);
      checkValue($sformatf("wrap%0d count", i), int'(count), 1);
      applyStimulus(0, 0, 1, 0);
      checkValue($sformatf("wrap%0d empty", i), int'(empty), 1);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      bit iv;
      bit rdy;
      bit c;
      int v;
      iv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      c   = ($urandom_range(0, 19) == 0);
      v   = int'($urandom_range(0, 2047)) - 1024;
      applyStimulus(iv, v, rdy, c);
      checkOutput($sformatf("rand%0d", i));
    end

    // Reset in the middle of operation with five entries stored
    for (int i = 0; i < DEPTH + 2 && q.size() > 0; i++) begin
      applyStimulus(0, 0, 1, 0);
    end
    for (int v = 0; v < 5; v++) begin
      applyStimulus(1, 10 * v + 3, 0, 0);
    end
    checkValue("pre-reset count", int'(count), 5);
    reset = 1'b0;
    #1;
    modelReset();
    checkValue("midrst count", int'(count), 0);
    checkValue("midrst empty", int'(empty), 1);
    checkValue("midrst full", int'(full), 0);
    checkValue("midrst dout_valid", int'(dout_valid), 0);
    checkValue("midrst drop_err", int'(drop_err), 0);
    checkValue("midrst max_val", int'(max_val), MINV);
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(1, 100, 0, 0);
    checkValue("postrst dout", int'(dout), 100);
    checkValue("postrst count", int'(count), 1);
    checkOutput("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_result_fifo.md
MAC_RESULT_FIFO -- requirements
Module: mac_result_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, FIFO entry count; power of two, 2..16.
REQ-002 The block SHALL have parameter DW, default 11, result width; matches the MAC accumulator output.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk  input  1  clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous active-low reset.
REQ-006 Port in_data  input  DW  signed dot-product result from the upstream MAC.
REQ-007 Port in_valid  input  1  single-cycle strobe qualifying in_data.
REQ-008 Port dout  output  DW  signed FIFO head (show-ahead).
REQ-009 Port dout_valid  output  1  high when dout holds a valid entry.
REQ-010 Port dout_ready  input  1  consumer accepts dout this cycle.
REQ-011 Port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-012 Port full  output  1  count == DEPTH.
REQ-013 Port empty  output  1  count == 0.
REQ-014 Port drop_err  output  1  sticky flag: a result was lost to overflow.
REQ-015 Port max_val  output  DW  signed maximum of results seen since the last clear.
REQ-016 Port clr  input  1  synchronous clear of max_val and drop_err only.

Function
REQ-017 Push SHALL occur when in_valid=1 and (full=0 or pop occurs in the same cycle).
REQ-018 Pop SHALL occur when dout_valid=1 and dout_ready=1.
REQ-019 dout_valid SHALL equal !empty; dout SHALL be memory[rd_ptr], and SHALL be don't-care when empty.
REQ-020 Latency: data pushed at edge k SHALL appear on dout with dout_valid=1 immediately after edge k if the FIFO was empty.
REQ-021 count SHALL update: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-023 Push+pop when full SHALL write the new entry and read the head; count stays DEPTH.
REQ-024 Push+pop when empty: pop is impossible (dout_valid=0); the push SHALL proceed and count becomes 1.
REQ-025 in_valid=1 with full=1 and no pop SHALL drop in_data, leave the FIFO unchanged, and set drop_err=1 at that edge.
REQ-026 drop_err SHALL hold until clr=1 or reset; if clr and a drop coincide, drop_err SHALL be 1.
REQ-027 max_val SHALL update on every in_valid=1, including dropped results: max_val <= max(max_val, in_data), signed compare.
REQ-028 clr=1 without in_valid SHALL set max_val to the most negative value (-1024 for DW=11).
REQ-029 clr=1 together with in_valid=1 SHALL set max_val <= in_data.
REQ-030 FIFO contents and count SHALL be unaffected by clr.
REQ-031 All outputs SHALL be registered or decoded directly from registers, with no combinational path from in_data to dout.

Reset
REQ-032 reset=0 SHALL immediately force count=0, rd/wr pointers=0, empty=1, full=0, dout_valid=0, drop_err=0, max_val=most negative value.
REQ-033 Memory contents SHALL NOT require reset; dout SHALL be ignored while empty.
REQ-034 Reset asserted mid-operation SHALL discard all entries; the first push after deassertion SHALL land in entry 0.
REQ-035 Reset deassertion SHALL be synchronised externally; the block SHALL NOT act on in_valid during the reset-release edge.

Verification
REQ-036 Single push, for example in_valid pulse with in_data=37 and dout_ready=0 -> next cycle: dout=37, dout_valid=1, count=1, max_val=37.
REQ-037 Fill and overflow: 9 pushes of values 1..9 with dout_ready=0 -> full=1, count=8, drop_err=1, max_val=9; draining yields 1..8 in order, then empty=1.
REQ-038 Simultaneous push and pop at full: push -5 with dout_ready=1 -> head popped, count stays 8, drop_err unchanged, -5 read last.
REQ-039 Negative maximum and clear: after clr, push -300 then -12 -> max_val=-12; clr together with a push of -700 -> max_val=-700.
REQ-040 Pointer wrap: 20 push/pop pairs with random signed values -> output order matches input order, count never exceeds 1.
REQ-041 Reset mid-operation: reset=0 with count=5 -> immediately count=0, empty=1, drop_err=0; after release, push 100 -> dout=100.
